controle_busca: RTL

CONTROLE_BUSCA -- requirements
Module: controle_busca

---
 rtl/controle_busca_pkg.sv | 26 ++
 rtl/controle_busca_fila.sv | 45 ++++
 rtl/controle_busca.sv | 123 ++++++++++++
 3 files changed

// File: rtl/controle_busca_pkg.sv
// Shared types and constants for the instruction fetch unit.
package controle_busca_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 3;  // holds 0..4, the largest queue depth
  localparam int PTR_W   = 2;  // addresses up to 4 slots

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } estado_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entrada_t;

  // Advance a queue pointer, wrapping at the configured depth.
  function automatic logic [PTR_W-1:0] avanca_ptr(input logic [PTR_W-1:0] p,
                                                  input int depth);
    return (int'(p) == depth - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/controle_busca_fila.sv
// fila_busca: small synchronous FIFO of fetched {pc, instr} entries with flush.
// The head reads as zero whenever the queue is empty.
module fila_busca
  import controle_busca_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  entrada_t         dado_i,
  output entrada_t         cabeca_o,
  output logic [CNT_W-1:0] count_o
);

  // Storage is sized for the maximum depth so the 2-bit pointers index it
  // exactly; pointers only ever visit slots 0..QDEPTH-1.
  entrada_t         mem_q [4];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= avanca_ptr(wr_q, QDEPTH);
      if (pop_i)  rd_q <= avanca_ptr(rd_q, QDEPTH);
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, push_i} - {{(CNT_W-1){1'b0}}, pop_i};
    end
  end

  // Entry storage; contents are don't-care while not counted as valid.
  always_ff @(posedge clk) begin
    if (push_i && !reset && !flush_i) mem_q[wr_q] <= dado_i;
  end

  assign cabeca_o = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o  = cnt_q;

endmodule

// File: rtl/controle_busca.sv
// controle_busca: fetch control FSM, PC and fetch counter in front of fila_busca.
// Optional macro FETCH_BOUND_CHECK_EN halts fetch on a PC beyond MEM_WORDS.
module controle_busca
  import controle_busca_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int RESET_PC  = 0,
  parameter int QDEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [31:0]        fetch_count,
  output logic               fault
);

  if (QDEPTH < 1 || QDEPTH > 4 || MEM_WORDS < 1) begin : g_param_err
    $error("controle_busca: QDEPTH must be 1..4 and MEM_WORDS >= 1");
  end

  estado_t          state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      fc_q, fc_d;
  logic             fault_q, fault_d;
  logic             push, pop, flush, space, oob;
  logic [CNT_W-1:0] cnt;
  entrada_t         cabeca;

`ifdef FETCH_BOUND_CHECK_EN
  assign oob = (pc_q >= PC_W'(MEM_WORDS));
`else
  assign oob = 1'b0;
`endif

  // Redirect outranks the consumer: a flushed head is never counted as popped.
  assign pop   = out_valid && out_ready && !redirect_valid;
  assign space = (int'(cnt) < QDEPTH) || pop;

  // Next-state, PC and push decision.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fc_d    = fc_q;
    fault_d = fault_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          pc_d  = redirect_pc;
          flush = 1'b1;
        end
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_d  = redirect_pc;
          flush = 1'b1;
        end else if (space) begin
          if (oob) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = pc_q + 1'b1;
            fc_d = fc_q + 1'b1;
          end
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          flush   = 1'b1;
          fault_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC, counter and fault registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(RESET_PC);
      fc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fc_q    <= fc_d;
      fault_q <= fault_d;
    end
  end

  fila_busca #(.QDEPTH(QDEPTH)) u_fila (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush),
    .push_i   (push),
    .pop_i    (pop),
    .dado_i   ('{pc: pc_q, instr: mem_instr}),
    .cabeca_o (cabeca),
    .count_o  (cnt)
  );

  assign mem_addr    = pc_q;
  assign out_valid   = (cnt != '0);
  assign out_instr   = cabeca.instr;
  assign out_pc      = cabeca.pc;
  assign fetch_count = fc_q;
  assign fault       = fault_q;

endmodule
